// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: muxes NCH sram-like masters onto one slave; in: m_req/m_wr/m_size/m_addr/m_wdata, s_addr_ok/s_data_ok/s_rdata; out: m_addr_ok/m_data_ok/m_rdata, s_req/s_wr/s_size/s_addr/s_wdata, busy
module sram_like_arbiter #(
  parameter int NCH = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int OUTS = 2,
  parameter int RR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    m_req,
  input  logic [NCH-1:0]    m_wr,
  input  logic [2*NCH-1:0]  m_size,
  input  logic [AW*NCH-1:0] m_addr,
  input  logic [DW*NCH-1:0] m_wdata,
  output logic [NCH-1:0]    m_addr_ok,
  output logic [NCH-1:0]    m_data_ok,
  output logic [DW-1:0]     m_rdata,
  output logic              s_req,
  output logic              s_wr,
  output logic [1:0]        s_size,
  output logic [AW-1:0]     s_addr,
  output logic [DW-1:0]     s_wdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  input  logic [DW-1:0]     s_rdata,
  output logic              busy
);
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int PW = OUTS > 1 ? $clog2(OUTS) : 1;
  localparam int CW = $clog2(OUTS + 1);
  typedef enum logic {OPEN, LOCKED} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] lock_id_q, lock_id_d, rr_last_q, rr_last_d, g;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] fifo_q [OUTS];
  logic req, hs, rs;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(OUTS - 1) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    g = '0;
    if (RR == 0) begin
      for (int i = 0; i < NCH; i++) if (m_req[i]) g = IW'(i);
    end else begin
      int best, d;
      best = NCH;
      for (int i = 0; i < NCH; i++) begin
        d = (i + NCH - 1 - int'(rr_last_q)) % NCH;
        if (m_req[i] && d < best) begin
          best = d;
          g = IW'(i);
        end
      end
    end
    if (state_q == LOCKED) g = lock_id_q;
  end
  assign req = (|m_req || state_q == LOCKED) && count_q < CW'(OUTS);
  assign hs = req && s_addr_ok;
  assign rs = s_data_ok && count_q != '0;
  always_comb begin
    s_req = !reset && req;
    s_wr = 1'b0;
    s_size = '0;
    s_addr = '0;
    s_wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!reset && g == IW'(i)) begin
        s_wr = m_wr[i];
        s_size = m_size[2*i +: 2];
        s_addr = m_addr[AW*i +: AW];
        s_wdata = m_wdata[DW*i +: DW];
      end
    end
    m_addr_ok = !reset && hs ? NCH'(1) << g : '0;
    m_data_ok = !reset && rs ? NCH'(1) << fifo_q[rd_ptr_q] : '0;
    m_rdata = reset ? '0 : s_rdata;
    busy = !reset && count_q != '0;
  end
  always_comb begin
    state_d = state_q;
    lock_id_d = lock_id_q;
    rr_last_d = rr_last_q;
    wr_ptr_d = hs ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rs ? nxt(rd_ptr_q) : rd_ptr_q;
    count_d = count_q + CW'(hs) - CW'(rs);
    if (hs) begin
      state_d = OPEN;
      rr_last_d = RR != 0 ? g : rr_last_q;
    end else if (req) begin
      state_d = LOCKED;
      lock_id_d = g;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OPEN;
      lock_id_q <= '0;
      rr_last_q <= IW'(NCH - 1);
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      lock_id_q <= lock_id_d;
      rr_last_q <= rr_last_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) if (hs) fifo_q[wr_ptr_q] <= g;
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: random and directed checks of two arbiter configurations against a queue-based model
module tb_sram_like_arbiter;
  logic clk = 0;
  logic reset;
  logic [3:0] m_req, m_wr;
  logic [7:0] m_size;
  logic [127:0] m_addr, m_wdata;
  logic s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;
  logic [1:0] a_addr_ok, a_data_ok;
  logic [31:0] a_rdata, a_s_addr, a_s_wdata;
  logic a_s_req, a_s_wr, a_busy;
  logic [1:0] a_s_size;
  logic [3:0] b_addr_ok, b_data_ok;
  logic [31:0] b_rdata, b_s_addr, b_s_wdata;
  logic b_s_req, b_s_wr, b_busy;
  logic [1:0] b_s_size;
  int n_cmp = 0, n_err = 0;
  int q [2][$];
  bit lk [2];
  int lid [2], rrl [2];
  always #5 clk = ~clk;
  sram_like_arbiter dut_a (
    .clk(clk), .reset(reset), .m_req(m_req[1:0]), .m_wr(m_wr[1:0]), .m_size(m_size[3:0]),
    .m_addr(m_addr[63:0]), .m_wdata(m_wdata[63:0]), .m_addr_ok(a_addr_ok), .m_data_ok(a_data_ok),
    .m_rdata(a_rdata), .s_req(a_s_req), .s_wr(a_s_wr), .s_size(a_s_size), .s_addr(a_s_addr),
    .s_wdata(a_s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata), .busy(a_busy)
  );
  sram_like_arbiter #(.NCH(4), .OUTS(3), .RR(1)) dut_b (
    .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(b_addr_ok), .m_data_ok(b_data_ok),
    .m_rdata(b_rdata), .s_req(b_s_req), .s_wr(b_s_wr), .s_size(b_s_size), .s_addr(b_s_addr),
    .s_wdata(b_s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata), .busy(b_busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_update();
    for (int k = 0; k < 2; k++) begin
      int n, outs, g;
      bit sreq, hs, rsp;
      string p;
      logic [63:0] o_req, o_wr, o_size, o_addr, o_wdata, o_aok, o_dok, o_rdata, o_busy;
      n = k ? 4 : 2;
      outs = k ? 3 : 2;
      p = k ? "B." : "A.";
      if (k == 0) begin
        o_req = a_s_req; o_wr = a_s_wr; o_size = a_s_size; o_addr = a_s_addr; o_wdata = a_s_wdata;
        o_aok = a_addr_ok; o_dok = a_data_ok; o_rdata = a_rdata; o_busy = a_busy;
      end else begin
        o_req = b_s_req; o_wr = b_s_wr; o_size = b_s_size; o_addr = b_s_addr; o_wdata = b_s_wdata;
        o_aok = b_addr_ok; o_dok = b_data_ok; o_rdata = b_rdata; o_busy = b_busy;
      end
      if (reset) begin
        check({p, "rst_s_req"}, o_req, 0);
        check({p, "rst_fields"}, o_wr | o_size | o_addr | o_wdata, 0);
        check({p, "rst_addr_ok"}, o_aok, 0);
        check({p, "rst_data_ok"}, o_dok, 0);
        check({p, "rst_rdata"}, o_rdata, 0);
        check({p, "rst_busy"}, o_busy, 0);
        q[k].delete();
        lk[k] = 0;
        lid[k] = 0;
        rrl[k] = n - 1;
      end else begin
        g = 0;
        if (lk[k]) g = lid[k];
        else if (k == 0) begin
          for (int i = 0; i < n; i++) if (m_req[i]) g = i;
        end else begin
          for (int j = n; j >= 1; j--) if (m_req[(rrl[k] + j) % n]) g = (rrl[k] + j) % n;
        end
        sreq = ((m_req & (k ? 4'hf : 4'h3)) != 0 || lk[k]) && q[k].size() < outs;
        hs = sreq && s_addr_ok;
        rsp = s_data_ok && q[k].size() != 0;
        check({p, "s_req"}, o_req, sreq);
        if (sreq) begin
          check({p, "s_wr"}, o_wr, m_wr[g]);
          check({p, "s_size"}, o_size, m_size[2*g +: 2]);
          check({p, "s_addr"}, o_addr, m_addr[32*g +: 32]);
          check({p, "s_wdata"}, o_wdata, m_wdata[32*g +: 32]);
        end
        check({p, "addr_ok"}, o_aok, hs ? 64'(1) << g : 64'(0));
        check({p, "data_ok"}, o_dok, rsp ? 64'(1) << q[k][0] : 64'(0));
        check({p, "rdata"}, o_rdata, s_rdata);
        check({p, "busy"}, o_busy, q[k].size() != 0);
        if (rsp) void'(q[k].pop_front());
        if (hs) begin
          q[k].push_back(g);
          lk[k] = 0;
          if (k == 1) rrl[k] = g;
        end else if (sreq) begin
          lk[k] = 1;
          lid[k] = g;
        end
      end
    end
  endtask
  task automatic step(input logic rs, input logic [3:0] rq, input logic ao, input logic dk, input logic [31:0] rd);
    @(negedge clk);
    reset = rs;
    m_req = rq;
    s_addr_ok = ao;
    s_data_ok = dk;
    s_rdata = rd;
    #2;
    check_update();
  endtask
  task automatic rstep();
    @(negedge clk);
    reset = $urandom_range(0, 299) == 0;
    for (int i = 0; i < 4; i++) begin
      if (!((i < 2 && lk[0] && lid[0] == i) || (lk[1] && lid[1] == i))) begin
        m_req[i] = $urandom_range(0, 9) < 6;
        m_wr[i] = 1'($urandom);
        m_size[2*i +: 2] = 2'($urandom);
        m_addr[32*i +: 32] = $urandom;
        m_wdata[32*i +: 32] = $urandom;
      end
    end
    s_addr_ok = $urandom_range(0, 2) != 0;
    s_data_ok = $urandom_range(0, 2) == 0;
    s_rdata = $urandom;
    #2;
    check_update();
  endtask
  initial begin
    reset = 1;
    m_req = '0;
    s_addr_ok = 0;
    s_data_ok = 0;
    s_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      m_wr[i] = i[0];
      m_size[2*i +: 2] = 2'(i);
      m_addr[32*i +: 32] = 32'h1000_0000 + 32'(i * 16);
      m_wdata[32*i +: 32] = 32'hA000_0000 + 32'(i);
    end
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 4'b0011, 1, 0, 0);
    check("fixed_ack", a_addr_ok, 2'b10);
    check("fixed_addr", a_s_addr, 32'h1000_0010);
    step(0, 0, 0, 0, 0);
    check("fixed_busy", a_busy, 1);
    step(1, 0, 0, 0, 0);
    step(0, 4'b0001, 0, 0, 0);
    step(0, 4'b0011, 0, 0, 0);
    check("lock_hold", a_s_addr, 32'h1000_0000);
    step(0, 4'b0011, 0, 0, 0);
    step(0, 4'b0011, 1, 0, 0);
    check("lock_ack", a_addr_ok, 2'b01);
    step(0, 4'b0010, 1, 0, 0);
    check("lock_next", a_addr_ok, 2'b10);
    step(0, 4'b0011, 1, 0, 0);
    check("full_s_req", a_s_req, 0);
    step(0, 4'b0000, 0, 1, 32'h1234_5678);
    check("full_data_ok", a_data_ok, 2'b01);
    check("full_rdata", a_rdata, 32'h1234_5678);
    step(0, 4'b0001, 1, 0, 0);
    check("full_resume", a_s_req, 1);
    step(1, 4'b0001, 1, 1, 0);
    check("mid_rst_busy", a_busy, 0);
    step(0, 0, 0, 1, 32'hDEAD_BEEF);
    check("post_rst_data_ok", a_data_ok, 0);
    check("post_rst_busy", a_busy, 0);
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      step(0, 4'hf, 1, 1, 32'(c));
      check("rr_order", b_addr_ok, 4'(1) << (c % 4));
    end
    for (int c = 0; c < 7; c++) begin
      step(0, 4'b0011, 1, 1, $urandom);
      check("wrap_busy", a_busy, 1);
    end
    for (int c = 0; c < 4000; c++) rstep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Parametrised N-channel arbiter that multiplexes the CPU's sram-like master ports onto one sram-like slave port (e.g. inst and data onto one cache/bridge port).
- Sits between the pipeline's instruction/data interfaces and the memory-side bridge.
- Supports up to OUTS in-flight transactions.
- Uses an in-order channel-ID FIFO to route data_ok back to the issuing channel.

Parameters:
- NCH, 2, number of master channels (channel 0 = inst, highest index = data).
- AW, 32, address width.
- DW, 32, data width.
- OUTS, 2, maximum accepted-but-unanswered transactions, at least 1.
- RR, 0, arbitration mode: 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- m_req  in  NCH  per-channel request.
- m_wr  in  NCH  per-channel write flag.
- m_size  in  2*NCH  per-channel size; channel i occupies bits [2i+1:2i].
- m_addr  in  AW*NCH  per-channel address, packed the same way.
- m_wdata  in  DW*NCH  per-channel write data.
- m_addr_ok  out  NCH  request accepted, one-hot or zero.
- m_data_ok  out  NCH  response returned, one-hot or zero.
- m_rdata  out  DW  read data, broadcast to all channels.
- s_req  out  1  slave request.
- s_wr  out  1  slave write flag.
- s_size  out  2  slave size.
- s_addr  out  AW  slave address.
- s_wdata  out  DW  slave write data.
- s_addr_ok  in  1  slave accepted the request.
- s_data_ok  in  1  slave response valid.
- s_rdata  in  DW  slave read data.
- busy  out  1  count != 0.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- While reset is high, all outputs are forced to 0.
- Registers on reset: lock=0, lock_id=0, FIFO rd_ptr=wr_ptr=0, count=0, rr_last=NCH-1 (so channel 0 is first under RR).
- ID width: IW=max(1,clog2(NCH)). FIFO depth is OUTS entries of IW bits. Pointers wrap modulo OUTS.
- Grant g (combinational):
  - if lock=1, g=lock_id;
  - else RR=0: highest i with m_req[i];
  - else RR=1: first i with m_req[i], scanning (rr_last+1) mod NCH upward with wrap.
- s_req = any m_req (or lock) AND count<OUTS. The full check does not see a same-cycle pop; no bypass.
- s_wr/s_size/s_addr/s_wdata mux channel g. When s_req=0 they are don't-care; the implementation drives channel g's fields.
- Handshake HS = s_req & s_addr_ok:
  - m_addr_ok[g]=1, all other bits 0;
  - push g into the FIFO;
  - clear lock;
  - if RR=1, rr_last<=g.
- If s_req=1 and s_addr_ok=0: lock<=1 and lock_id<=g. The slave sees stable request fields until acceptance, even if a higher-priority channel raises req.
- Masters must hold req and its fields until addr_ok. A master dropping req while locked is a protocol violation; behaviour is unspecified.
- Response RS = s_data_ok & count!=0:
  - m_data_ok[FIFO head]=1, same cycle (combinational);
  - m_rdata = s_rdata;
  - pop.
- s_data_ok with count==0: ignored, no m_data_ok, no state change.
- HS and RS in the same cycle: push and pop both occur; count unchanged; head advances.
- The slave must return responses in acceptance order; no reordering support.
- Latency: zero added cycles in both directions (pure combinational path plus bookkeeping).
- Reset mid-operation clears the FIFO and lock. Any in-flight responses arriving afterwards are dropped by the count==0 rule.

Test Plan:
- Reset, then m_req=2'b11 with s_addr_ok=1 constant (RR=0) -> s_addr=channel 1 address; m_addr_ok=2'b10; FIFO holds {1}; busy=1.
- Lock: ch0 requests with s_addr_ok=0 for 3 cycles, ch1 raises req in cycle 2 -> s_addr stays ch0 until s_addr_ok; then m_addr_ok=2'b01; ch1 is granted the next cycle.
- OUTS=2: accept ch0 then ch1 with no data_ok -> s_req=0 while count=2; then s_data_ok with s_rdata=0x12345678 -> m_data_ok=2'b01, m_rdata=0x12345678; s_req reasserts the next cycle.
- RR=1, NCH=4, all m_req=1, s_addr_ok=1 for 5 cycles -> grant order 0,1,2,3,0.
- Same-cycle HS and RS at count=1 -> count stays 1; m_data_ok goes to the older ID; the FIFO wraps correctly over 2*OUTS+1 transactions.
- Spurious s_data_ok at count=0 -> m_data_ok=0. Reset asserted with count=2 -> count=0, all outputs 0, and subsequent s_data_ok is ignored.
